// File: rtl/sprite_pixel_fetch.sv
// Sprite ROM read pipeline: raster position -> texel address -> palette RGB + hit, with per-frame opaque count.
// Optional horizontal mirroring is built only when SPRITE_FLIP_EN is defined.
module sprite_pixel_fetch #(
    parameter int SCALE_LOG2 = 1,
    parameter int SCREEN_W   = 640
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_start,
    input  logic        pix_valid_in,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  SpriteX,
    input  logic [9:0]  SpriteY,
    input  logic        flip_in,
    input  logic        visible_in,
    output logic [3:0]  rom_X,
    output logic [3:0]  rom_Y,
    input  logic [1:0]  rom_pal,
    output logic        pix_valid_out,
    output logic        hit,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic [15:0] opaque_count
);

    localparam logic [9:0] SPAN  = 10'(16 << SCALE_LOG2);
    localparam logic [9:0] SCR_W = 10'(SCREEN_W);

    logic [9:0]  shx, shy;
    logic        shvis;
    logic [15:0] cnt;
    logic        v1, in1;
    logic [10:0] dx, dy;
    logic        inbox;
    logic [3:0]  col, row, col_f;
    logic [11:0] rgb_pal;

    // 11-bit difference keeps the sign, so sprites near the right/bottom edge never wrap
    assign dx = {1'b0, DrawX} - {1'b0, shx};
    assign dy = {1'b0, DrawY} - {1'b0, shy};
    assign inbox = shvis && (shx < SCR_W) && !dx[10] && !dy[10]
                   && (dx[9:0] < SPAN) && (dy[9:0] < SPAN);
    assign col = dx[SCALE_LOG2 +: 4];
    assign row = dy[SCALE_LOG2 +: 4];

`ifdef SPRITE_FLIP_EN
    logic shflip;
    assign col_f = shflip ? (4'd15 - col) : col;
`else
    logic unused_flip;
    assign unused_flip = flip_in;
    assign col_f = col;
`endif

    always_comb begin
        rgb_pal = 12'h000;
        case (rom_pal)
            2'b01:   rgb_pal = 12'hF00;
            2'b10:   rgb_pal = 12'h630;
            2'b11:   rgb_pal = 12'hFA5;
            default: rgb_pal = 12'h000;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            shx           <= '0;
            shy           <= '0;
            shvis         <= 1'b0;
`ifdef SPRITE_FLIP_EN
            shflip        <= 1'b0;
`endif
            cnt           <= '0;
            opaque_count  <= '0;
            v1            <= 1'b0;
            in1           <= 1'b0;
            rom_X         <= '0;
            rom_Y         <= '0;
            pix_valid_out <= 1'b0;
            hit           <= 1'b0;
            red           <= '0;
            green         <= '0;
            blue          <= '0;
        end else begin
            if (frame_start) begin
                shx          <= SpriteX;
                shy          <= SpriteY;
                shvis        <= visible_in;
`ifdef SPRITE_FLIP_EN
                shflip       <= flip_in;
`endif
                opaque_count <= cnt;
                // a hit landing on the handoff cycle belongs to the new frame
                cnt          <= hit ? 16'd1 : 16'd0;
            end else if (hit && cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end

            v1  <= pix_valid_in;
            in1 <= pix_valid_in && inbox;
            if (pix_valid_in && inbox) begin
                rom_X <= col_f;
                rom_Y <= row;
            end

            pix_valid_out <= v1;
            hit           <= v1 && in1 && (rom_pal != 2'b00);
            {red, green, blue} <= (v1 && in1) ? rgb_pal : 12'h000;
        end
    end

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Randomized bench for sprite_pixel_fetch against a frame-level behavioural model (honours SPRITE_FLIP_EN).
module tb_sprite_pixel_fetch;

    localparam int S    = 1;
    localparam int SPAN = 16 << S;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_start = 1'b0, pix_valid_in = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0, SpriteX = '0, SpriteY = '0;
    logic        flip_in = 1'b0, visible_in = 1'b0;
    logic [3:0]  rom_X, rom_Y;
    logic [1:0]  rom_pal;
    logic        pix_valid_out, hit;
    logic [3:0]  red, green, blue;
    logic [15:0] opaque_count;

    logic [1:0]  rom_tbl [16][16];
    assign rom_pal = rom_tbl[rom_Y][rom_X];

    sprite_pixel_fetch #(.SCALE_LOG2(S), .SCREEN_W(640)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
        .pix_valid_in(pix_valid_in), .DrawX(DrawX), .DrawY(DrawY),
        .SpriteX(SpriteX), .SpriteY(SpriteY), .flip_in(flip_in),
        .visible_in(visible_in), .rom_X(rom_X), .rom_Y(rom_Y),
        .rom_pal(rom_pal), .pix_valid_out(pix_valid_out), .hit(hit),
        .red(red), .green(green), .blue(blue), .opaque_count(opaque_count)
    );

    always #5 Clk = ~Clk;

    typedef struct { bit v; bit h; logic [11:0] rgb; } exp_t;

    int   n_checks = 0, n_errors = 0;
    int   m_sx, m_sy;
    bit   m_vis, m_flip;
    exp_t p1, p2;
    int   run_cnt, exp_oc;
    bit   last_hit;
    int   exp_rx, exp_ry;
    int   nz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] pal_rgb(input int p);
        case (p)
            1: return 12'hF00;
            2: return 12'h630;
            3: return 12'hFA5;
            default: return 12'h000;
        endcase
    endfunction

    task automatic model_reset();
        m_sx = 0; m_sy = 0; m_vis = 0; m_flip = 0;
        p1 = '{0, 0, 12'h0}; p2 = '{0, 0, 12'h0};
        run_cnt = 0; exp_oc = 0; last_hit = 0; exp_rx = 0; exp_ry = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_vout"}, pix_valid_out, 0);
        chk({tag, "_hit"}, hit, 0);
        chk({tag, "_rgb"}, {red, green, blue}, 0);
        chk({tag, "_cnt"}, opaque_count, 0);
        chk({tag, "_romxy"}, {rom_X, rom_Y}, 0);
    endtask

    task automatic reset_dut(input int cycles);
        Reset_n = 1'b0; frame_start = 1'b0; pix_valid_in = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge Clk); #1;
            check_all_zero("reset");
        end
        Reset_n = 1'b1;
        model_reset();
    endtask

    // One clock: drive this cycle's inputs, advance model, compare what the edge produced.
    task automatic step(input bit fs, input bit pv, input int x, input int y);
        exp_t e;
        bit   inb, fl;
        int   dxm, dym, col, row, pal;
        frame_start = fs; pix_valid_in = pv; DrawX = 10'(x); DrawY = 10'(y);
        dxm = x - m_sx; dym = y - m_sy;
        inb = m_vis && m_sx < 640 && dxm >= 0 && dym >= 0 && dxm < SPAN && dym < SPAN;
        col = dxm / (1 << S); row = dym / (1 << S);
`ifdef SPRITE_FLIP_EN
        fl = m_flip;
`else
        fl = 0;
`endif
        if (fl) col = 15 - col;
        pal = inb ? int'(rom_tbl[row][col]) : 0;
        e.v = pv; e.h = pv && inb && pal != 0; e.rgb = (pv && inb) ? pal_rgb(pal) : 12'h0;
        if (pv && inb) begin exp_rx = col; exp_ry = row; end
        if (fs) begin
            m_sx = SpriteX; m_sy = SpriteY; m_vis = visible_in; m_flip = flip_in;
        end
        @(posedge Clk); #1;
        p2 = p1; p1 = e;
        if (fs) begin
            exp_oc = (run_cnt > 65535) ? 65535 : run_cnt;
            run_cnt = last_hit;
        end else begin
            run_cnt += last_hit;
        end
        last_hit = p2.h;
        chk("vout", pix_valid_out, p2.v);
        chk("hit", hit, p2.h);
        chk("rgb", {red, green, blue}, p2.rgb);
        chk("opaque_count", opaque_count, exp_oc);
        chk("rom_xy", {rom_X, rom_Y}, {4'(exp_rx), 4'(exp_ry)});
    endtask

    task automatic set_sprite(input int sx, input int sy, input bit vis, input bit fl);
        SpriteX = 10'(sx); SpriteY = 10'(sy); visible_in = vis; flip_in = fl;
    endtask

    initial begin
        nz = 0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                rom_tbl[r][c] = 2'($urandom_range(0, 3));
                if (rom_tbl[r][c] != 0) nz++;
            end
        model_reset();

        reset_dut(3);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        check_all_zero("idle");

        // basic fetch with directed latency checks
        set_sprite(100, 50, 1, 0);
        step(1, 0, 0, 0);
        step(0, 1, 102, 51);
        chk("basic_romx", rom_X, 1);
        chk("basic_romy", rom_Y, 0);
        chk("basic_vout_early", pix_valid_out, 0);
        step(0, 0, 0, 0);
        chk("basic_vout_2cyc", pix_valid_out, 1);
        chk("basic_hit", hit, rom_tbl[0][1] != 0);
        step(0, 0, 0, 0);

        // edges
        step(0, 1, 99, 51);
        step(0, 1, 131, 51);
        chk("edge_col15", rom_X, 15);
        step(0, 1, 132, 51);
        step(0, 1, 110, 82);
        step(0, 1, 110, 81);
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        chk("edge_y82_nohit", hit, 0);

        // tear-free: live position change is invisible until the next frame_start
        set_sprite(200, 50, 1, 0);
        for (int i = 0; i < 40; i++) step(0, 1, 96 + i, 60);
        step(1, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(0, 1, 196 + i, 60);

        // flip
        set_sprite(100, 50, 1, 1);
        step(1, 0, 0, 0);
        step(0, 1, 100, 50);
`ifdef SPRITE_FLIP_EN
        chk("flip_romx", rom_X, 15);
`else
        chk("flip_romx", rom_X, 0);
`endif
        step(0, 0, 0, 0); step(0, 0, 0, 0);

        // count sweep around the whole sprite footprint
        set_sprite(100, 50, 1, 0);
        step(1, 0, 0, 0);
        for (int y = 40; y < 90; y++)
            for (int x = 90; x < 140; x++) step(0, 1, x, y);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        set_sprite(100, 50, 0, 0);
        step(1, 0, 0, 0);
        chk("count_full", opaque_count, 4 * nz);
        for (int y = 48; y < 84; y++)
            for (int x = 98; x < 134; x++) step(0, 1, x, y);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("count_invisible", opaque_count, 0);

        // randomized traffic, including off-screen positions and frame_start under live hits
        set_sprite(100, 50, 1, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0)
                set_sprite($urandom_range(0, 99) < 10 ? $urandom_range(620, 1023) : $urandom_range(0, 200),
                           $urandom_range(0, 200), $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)));
            if (i == 1500) begin
                reset_dut(2);
                check_all_zero("midreset");
            end
            step($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 639), $urandom_range(0, 260));
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
